microsequencer: RTL and testbench

//  Next-state engine for the 2^8 x 64 control-store ROM. Drives STATE[7:0] into the ROM

---
 rtl/microsequencer_if.sv | 25 ++
 rtl/microsequencer.sv | 110 +++++++++++
 tb/tb_microsequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/microsequencer_if.sv
// Sequencing-field bundle between the control-store ROM side and the microsequencer.
// master drives the ROM word fields and conditions; slave returns STATE and status.
interface microsequencer_if;
    logic [2:0]  n;
    logic        inv;
    logic        mi;
    logic [2:0]  s;
    logic [15:0] cr;
    logic [7:0]  enc_addr;
    logic [7:0]  cond_in;
    logic [7:0]  state;
    logic        taken;
    logic [3:0]  stk_level;
    logic        stk_err;

    modport master (
        output n, inv, mi, s, cr, enc_addr, cond_in,
        input  state, taken, stk_level, stk_err
    );

    modport slave (
        input  n, inv, mi, s, cr, enc_addr, cond_in,
        output state, taken, stk_level, stk_err
    );
endinterface

// File: rtl/microsequencer.sv
// Next-microstate engine for the 256 x 64 control store.
// Optional return stack enabled by defining MSEQ_STACK_EN.
module microsequencer #(
    parameter logic [7:0] RESET_ADDR  = 8'd0,
    parameter logic [7:0] FETCH_ADDR  = 8'd1,
    parameter int         STACK_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    microsequencer_if.slave  bus
);
    logic [7:0] state_q, state_d;
    logic [7:0] inc;
    logic [7:0] ret_addr;
    logic       taken;
    logic       sel_cr;

    assign taken     = bus.cond_in[bus.s] ^ bus.inv;
    assign bus.taken = taken;
    assign bus.state = state_q;
    assign inc       = state_q + 8'd1;

    always_comb begin
        sel_cr  = 1'b0;
        state_d = inc;
        unique case (bus.n)
            3'd0: state_d = bus.enc_addr;
            3'd1: state_d = FETCH_ADDR;
            3'd2: state_d = inc;
            3'd3: sel_cr  = 1'b1;
            3'd4: sel_cr  = taken;
            3'd5: begin
                sel_cr  = taken;
                state_d = bus.cr[15:8];
            end
            3'd6: begin
                sel_cr  = taken;
                state_d = bus.enc_addr;
            end
            3'd7: state_d = ret_addr;
        endcase
        if (sel_cr)
            state_d = bus.cr[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= RESET_ADDR;
        else
            state_q <= state_d;
    end

`ifdef MSEQ_STACK_EN
    localparam int         IW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(STACK_DEPTH);

    logic [7:0]    stk_q [STACK_DEPTH];
    logic [3:0]    lvl_q, lvl_d;
    logic          err_q, err_d;
    logic          push, pop, full, empty;
    logic [IW-1:0] top_idx, wr_idx;

    // sel_cr is never set for N=7, so MI is ignored on a return
    assign push    = bus.mi & sel_cr;
    assign pop     = (bus.n == 3'd7);
    assign full    = (lvl_q == DEPTH4);
    assign empty   = (lvl_q == 4'd0);
    assign top_idx = IW'(lvl_q - 4'd1);
    assign wr_idx  = full ? IW'(STACK_DEPTH - 1) : IW'(lvl_q);
    assign ret_addr = empty ? FETCH_ADDR : stk_q[top_idx];

    always_comb begin
        lvl_d = lvl_q;
        err_d = err_q;
        if (push) begin
            if (full) err_d = 1'b1;
            else      lvl_d = lvl_q + 4'd1;
        end
        if (pop) begin
            if (empty) err_d = 1'b1;
            else       lvl_d = lvl_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push)
            stk_q[wr_idx] <= inc;
    end

    assign bus.stk_level = lvl_q;
    assign bus.stk_err   = err_q;
`else
    logic unused_call;

    assign unused_call   = &{1'b0, bus.mi, sel_cr};
    assign ret_addr      = FETCH_ADDR;
    assign bus.stk_level = 4'd0;
    assign bus.stk_err   = 1'b0;
`endif
endmodule

// File: tb/tb_microsequencer.sv
// Randomized self-checking bench for microsequencer against a queue-based model.
// Follows MSEQ_STACK_EN the same way the design does.
module tb_microsequencer;
    localparam logic [7:0] FETCH = 8'd1;
    localparam int         DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] m_state;
    logic [7:0] m_stk [$];
    logic       m_err;

    microsequencer_if bus();

    microsequencer #(
        .RESET_ADDR  (8'd0),
        .FETCH_ADDR  (FETCH),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        chk("state", 32'(bus.state), 32'(m_state));
        chk("level", 32'(bus.stk_level), 32'(m_stk.size()));
        chk("err", 32'(bus.stk_err), 32'(m_err));
    endtask

    task automatic rand_fields();
        bus.n        = 3'($urandom_range(0, 7));
        bus.inv      = 1'($urandom_range(0, 1));
        bus.mi       = 1'($urandom_range(0, 1));
        bus.s        = 3'($urandom_range(0, 7));
        bus.cr       = 16'($urandom);
        bus.enc_addr = 8'($urandom);
        bus.cond_in  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_fields();
        @(posedge clk);
        #1 rand_fields();
        @(posedge clk);
        #1;
        m_state = 8'd0;
        m_stk.delete();
        m_err = 1'b0;
        check_regs();
        rst = 1'b0;
    endtask

    // One microinstruction: drive fields, predict, clock, compare.
    task automatic cyc(input logic [2:0] n, input logic inv, input logic mi,
                       input logic [2:0] s, input logic [15:0] cr,
                       input logic [7:0] enc, input logic [7:0] cond);
        logic       c;
        logic [7:0] inc, nxt;
        logic       call;
        bus.n = n; bus.inv = inv; bus.mi = mi; bus.s = s;
        bus.cr = cr; bus.enc_addr = enc; bus.cond_in = cond;
        #1;
        c = cond[s] ^ inv;
        chk("taken", 32'(bus.taken), 32'(c));
        inc  = m_state + 8'd1;
        call = 1'b0;
        nxt  = inc;
        case (n)
            3'd0: nxt = enc;
            3'd1: nxt = FETCH;
            3'd2: nxt = inc;
            3'd3: begin nxt = cr[7:0]; call = mi; end
            3'd4: begin nxt = c ? cr[7:0] : inc;      call = mi & c; end
            3'd5: begin nxt = c ? cr[7:0] : cr[15:8]; call = mi & c; end
            3'd6: begin nxt = c ? cr[7:0] : enc;      call = mi & c; end
            default: begin
`ifdef MSEQ_STACK_EN
                if (m_stk.size() == 0) begin
                    nxt   = FETCH;
                    m_err = 1'b1;
                end else begin
                    nxt = m_stk.pop_back();
                end
`else
                nxt = FETCH;
`endif
            end
        endcase
`ifdef MSEQ_STACK_EN
        if (call) begin
            if (m_stk.size() == DEPTH) begin
                m_stk[$] = inc;
                m_err    = 1'b1;
            end else begin
                m_stk.push_back(inc);
            end
        end
`endif
        @(posedge clk);
        #1;
        m_state = nxt;
        check_regs();
    endtask

    task automatic go_to(input logic [7:0] a);
        cyc(3'd3, 1'b0, 1'b0, 3'd0, {8'h00, a}, 8'h00, 8'h00);
    endtask

    initial begin
        m_state = 8'd0;
        m_err   = 1'b0;
        #2;
        do_reset();
        chk("t1_reset_state", 32'(bus.state), 32'h0);
        cyc(3'd2, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t1_inc", 32'(bus.state), 32'h1);

        go_to(8'hFF);
        cyc(3'd2, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t2_wrap", 32'(bus.state), 32'h00);
        cyc(3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 8'd25, 8'h0);
        chk("t2_enc", 32'(bus.state), 32'd25);

        go_to(8'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(3'd4, 1'b1, 1'b0, 3'd0, 16'h0003, 8'h0, 8'h00);
            chk("t3_wait", 32'(bus.state), 32'd3);
        end
        cyc(3'd4, 1'b1, 1'b0, 3'd0, 16'h0003, 8'h0, 8'h01);
        chk("t3_moc", 32'(bus.state), 32'd4);

        cyc(3'd5, 1'b0, 1'b0, 3'd1, 16'h1E20, 8'h0, 8'h02);
        chk("t4_taken", 32'(bus.state), 32'd32);
        cyc(3'd5, 1'b0, 1'b0, 3'd1, 16'h1E20, 8'h0, 8'h00);
        chk("t4_alt", 32'(bus.state), 32'd30);

`ifdef MSEQ_STACK_EN
        go_to(8'd10);
        cyc(3'd3, 1'b0, 1'b1, 3'd0, 16'h0028, 8'h0, 8'h0);
        chk("t5_call", 32'(bus.state), 32'd40);
        chk("t5_lvl1", 32'(bus.stk_level), 32'd1);
        cyc(3'd7, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t5_ret", 32'(bus.state), 32'd11);
        cyc(3'd7, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t5_underflow", 32'(bus.state), 32'd1);
        chk("t5_err", 32'(bus.stk_err), 32'd1);
        for (int i = 0; i < 5; i++)
            cyc(3'd3, 1'b0, 1'b1, 3'd0, 16'(8'd50 + 8'(i)), 8'h0, 8'h0);
        chk("t5_full", 32'(bus.stk_level), 32'd4);
        cyc(3'd7, 1'b0, 1'b1, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t5_ovr_ret", 32'(bus.state), 32'd54);
`else
        go_to(8'd10);
        cyc(3'd3, 1'b0, 1'b1, 3'd0, 16'h0028, 8'h0, 8'h0);
        chk("t6_call", 32'(bus.state), 32'd40);
        chk("t6_lvl0", 32'(bus.stk_level), 32'd0);
        cyc(3'd7, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0, 8'h0);
        chk("t6_ret", 32'(bus.state), 32'd1);
        chk("t6_err", 32'(bus.stk_err), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    16'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
